poly_coef_extractor: RTL and testbench

- Hardware sequencer that drives the quadratic evaluator F(x,y,z) = a·x² + b·x + c·y² + d·y + e·z² + f·z + g, with 4-bit unsigned inputs, a 19-bit signed result and a done flag.
- Restarts the evaluator at seven probe points, captures each result and solves for the 5-bit signed coefficients a..g.
- Sits between a host start/status interface and the evaluator's clear/enable/input/done/out pins, replacing manual bench-driven coefficient recovery.

---
 rtl/poly_coef_extractor.sv | 211 +++++++++++++++++++++
 tb/tb_poly_coef_extractor.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/poly_coef_extractor.sv
// Probes a quadratic evaluator at seven points and solves for its 5-bit signed coefficients.
// Restarts the evaluator per point, waits for a done rising edge, then solves one axis per cycle.
module poly_coef_extractor #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               coef_valid,
  output logic               err,
  output logic [1:0]         err_code,
  output logic signed [4:0]  coef_a,
  output logic signed [4:0]  coef_b,
  output logic signed [4:0]  coef_c,
  output logic signed [4:0]  coef_d,
  output logic signed [4:0]  coef_e,
  output logic signed [4:0]  coef_f,
  output logic signed [4:0]  coef_g,
  output logic               eval_clr,
  output logic               eval_en,
  output logic [3:0]         eval_in0,
  output logic [3:0]         eval_in1,
  output logic [3:0]         eval_in2,
  input  logic               eval_done,
  input  logic signed [18:0] eval_out
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_SOLVE, S_DONE, S_ERR} state_t;

  state_t             state_q;
  logic [2:0]         idx_q;
  logic [1:0]         axis_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic signed [18:0] sample_q [7];

  logic               busy_q, coef_valid_q, err_q, eval_clr_q, eval_en_q;
  logic [1:0]         err_code_q;
  logic signed [4:0]  coef_a_q, coef_b_q, coef_c_q, coef_d_q, coef_e_q, coef_f_q, coef_g_q;
  logic [3:0]         in0_q, in1_q, in2_q;

  // Point order: origin, then (2-probe, 1-probe) pairs for x, y and z.
  function automatic logic [11:0] probe(input logic [2:0] i);
    case (i)
      3'd1:    probe = {4'd2, 4'd0, 4'd0};
      3'd2:    probe = {4'd1, 4'd0, 4'd0};
      3'd3:    probe = {4'd0, 4'd2, 4'd0};
      3'd4:    probe = {4'd0, 4'd1, 4'd0};
      3'd5:    probe = {4'd0, 4'd0, 4'd2};
      3'd6:    probe = {4'd0, 4'd0, 4'd1};
      default: probe = 12'd0;
    endcase
  endfunction

  function automatic logic signed [20:0] sext(input logic signed [18:0] v);
    sext = {{2{v[18]}}, v};
  endfunction

  function automatic logic in_rng(input logic signed [20:0] v);
    in_rng = (v >= -21'sd16) && (v <= 21'sd15);
  endfunction

  logic signed [20:0] g_w, s2_w, s1_w, p2_w, p1_w, qq_w, quad_w, lin_w;
  logic               rise_w, odd_w, range_bad_w;

  always_comb begin
    s2_w = '0;
    s1_w = '0;
    case (axis_q)
      2'd0:    begin s2_w = sext(sample_q[1]); s1_w = sext(sample_q[2]); end
      2'd1:    begin s2_w = sext(sample_q[3]); s1_w = sext(sample_q[4]); end
      default: begin s2_w = sext(sample_q[5]); s1_w = sext(sample_q[6]); end
    endcase
  end

  // F(2)-F(0) = 4q+2l and F(1)-F(0) = q+l, so Q = 2q must be even.
  assign g_w         = sext(sample_q[0]);
  assign p2_w        = s2_w - g_w;
  assign p1_w        = s1_w - g_w;
  assign qq_w        = p2_w - (p1_w <<< 1);
  assign quad_w      = qq_w >>> 1;
  assign lin_w       = p1_w - quad_w;
  assign odd_w       = qq_w[0];
  assign range_bad_w = !in_rng(quad_w) || !in_rng(lin_w) || ((axis_q == 2'd0) && !in_rng(g_w));
  assign rise_w      = eval_done & ~done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      axis_q       <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      coef_valid_q <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      eval_clr_q   <= 1'b0;
      eval_en_q    <= 1'b0;
      in0_q        <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      coef_a_q     <= '0;
      coef_b_q     <= '0;
      coef_c_q     <= '0;
      coef_d_q     <= '0;
      coef_e_q     <= '0;
      coef_f_q     <= '0;
      coef_g_q     <= '0;
      for (int i = 0; i < 7; i++) sample_q[i] <= '0;
    end else begin
      done_q <= eval_done;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q                <= S_CLR;
            idx_q                  <= '0;
            busy_q                 <= 1'b1;
            coef_valid_q           <= 1'b0;
            err_q                  <= 1'b0;
            err_code_q             <= 2'b00;
            eval_clr_q             <= 1'b1;
            {in0_q, in1_q, in2_q}  <= probe(3'd0);
          end
        end
        S_CLR: begin
          eval_clr_q <= 1'b0;
          eval_en_q  <= 1'b1;
          cnt_q      <= '0;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          // A rising edge in the final timeout cycle still counts.
          if (rise_w) begin
            sample_q[idx_q] <= eval_out;
            eval_en_q       <= 1'b0;
            if (idx_q != 3'd6) begin
              idx_q                 <= idx_q + 3'd1;
              eval_clr_q            <= 1'b1;
              {in0_q, in1_q, in2_q} <= probe(idx_q + 3'd1);
              state_q               <= S_CLR;
            end else begin
              axis_q  <= '0;
              state_q <= S_SOLVE;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            eval_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= 2'b01;
            state_q    <= S_ERR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SOLVE: begin
          if (odd_w || range_bad_w) begin
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= odd_w ? 2'b10 : 2'b11;
            state_q    <= S_ERR;
          end else begin
            case (axis_q)
              2'd0: begin
                coef_a_q <= quad_w[4:0];
                coef_b_q <= lin_w[4:0];
                coef_g_q <= g_w[4:0];
              end
              2'd1: begin
                coef_c_q <= quad_w[4:0];
                coef_d_q <= lin_w[4:0];
              end
              default: begin
                coef_e_q <= quad_w[4:0];
                coef_f_q <= lin_w[4:0];
              end
            endcase
            if (axis_q == 2'd2) begin
              busy_q       <= 1'b0;
              coef_valid_q <= 1'b1;
              state_q      <= S_DONE;
            end else begin
              axis_q <= axis_q + 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign coef_valid = coef_valid_q;
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign eval_clr   = eval_clr_q;
  assign eval_en    = eval_en_q;
  assign eval_in0   = in0_q;
  assign eval_in1   = in1_q;
  assign eval_in2   = in2_q;
  assign coef_a     = coef_a_q;
  assign coef_b     = coef_b_q;
  assign coef_c     = coef_c_q;
  assign coef_d     = coef_d_q;
  assign coef_e     = coef_e_q;
  assign coef_f     = coef_f_q;
  assign coef_g     = coef_g_q;

endmodule

// File: tb/tb_poly_coef_extractor.sv
// Bench for poly_coef_extractor: mock evaluator with configurable latency/faults,
// expected coefficients, error codes and timing derived from the quadratic itself.
module tb_poly_coef_extractor;

  logic               clk = 1'b0;
  logic               rst, start;
  logic               busy, coef_valid, err, eval_clr, eval_en, eval_done;
  logic [1:0]         err_code;
  logic signed [4:0]  coef_a, coef_b, coef_c, coef_d, coef_e, coef_f, coef_g;
  logic [3:0]         eval_in0, eval_in1, eval_in2;
  logic signed [18:0] eval_out;

  always #5 clk = ~clk;

  poly_coef_extractor #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .coef_valid(coef_valid),
    .err(err), .err_code(err_code),
    .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c), .coef_d(coef_d),
    .coef_e(coef_e), .coef_f(coef_f), .coef_g(coef_g),
    .eval_clr(eval_clr), .eval_en(eval_en),
    .eval_in0(eval_in0), .eval_in1(eval_in1), .eval_in2(eval_in2),
    .eval_done(eval_done), .eval_out(eval_out)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Mock evaluator state
  int ca, cb, cc, cd, ce, cf, cg;
  int lat = 1;
  bit hold_m = 0, never_m = 0, bad_m = 0;
  int run_cnt = 0;
  logic prev_done = 1'b0;
  logic ready, stale;

  function automatic int mock_f(input int x, input int y, input int z);
    if (bad_m && y == 0 && z == 0 && x == 2) return cg + 5;
    if (bad_m && y == 0 && z == 0 && x == 1) return cg + 3;
    return ca*x*x + cb*x + cc*y*y + cd*y + ce*z*z + cf*z + cg;
  endfunction

  always @(posedge clk) begin
    if (eval_clr) run_cnt <= 0;
    else if (eval_en) run_cnt <= run_cnt + 1;
    prev_done <= eval_done;
  end

  // done appears in RUN cycle 'lat'; hold mode keeps the previous done level
  // high through CLR and the first RUN cycle of the next point.
  assign ready     = eval_en && !never_m && (run_cnt >= lat - 1);
  assign stale     = hold_m && prev_done && (eval_clr || (eval_en && run_cnt == 0));
  assign eval_done = ready || stale;
  assign eval_out  = ready ? 19'(mock_f(int'(eval_in0), int'(eval_in1), int'(eval_in2))) : 19'h2AAAA;

  logic [11:0] clr_log[$];
  always @(posedge clk) if (eval_clr && !rst) clr_log.push_back({eval_in0, eval_in1, eval_in2});

  int px[7] = '{0, 2, 1, 0, 0, 0, 0};
  int py[7] = '{0, 0, 0, 2, 1, 0, 0};
  int pz[7] = '{0, 0, 0, 0, 0, 2, 1};

  task automatic set_c(input int a, b, c, d, e, f, g);
    ca = a; cb = b; cc = c; cd = d; ce = e; cf = f; cg = g;
  endtask

  function automatic bit rng(input int v);
    return v >= -16 && v <= 15;
  endfunction

  task automatic run(output int t0, output int t1);
    clr_log.delete();
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    t1 = -1;
    for (int i = 0; i < 3000; i++) begin
      if (coef_valid || err) begin
        t1 = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    if (t1 < 0) chk("run_bound", 0, 1);
  endtask

  task automatic check_result(input int t0, input int t1);
    int ax, code, base, nclr;
    ax = -1; code = 0;
    if (never_m) begin
      code = 1;
    end else if (bad_m) begin
      ax = 0; code = 2;
    end else if (!rng(ca) || !rng(cb) || !rng(cg)) begin
      ax = 0; code = 3;
    end else if (!rng(cc) || !rng(cd)) begin
      ax = 1; code = 3;
    end else if (!rng(ce) || !rng(cf)) begin
      ax = 2; code = 3;
    end
    base = t0 + 1 + 7 * (1 + lat);
    chk("busy_end", int'(busy), 0);
    chk("eval_en_end", int'(eval_en), 0);
    if (never_m) begin
      chk("timeout_time", t1 - t0, 66);
    end else if (code == 0) begin
      chk("done_latency", t1 - t0, base + 3 - t0);
    end else begin
      chk("err_latency", t1 - t0, base + ax + 1 - t0);
    end
    chk("err", int'(err), code != 0 ? 1 : 0);
    chk("err_code", int'(err_code), code);
    chk("coef_valid", int'(coef_valid), code == 0 ? 1 : 0);
    if (code == 0) begin
      chk("coef_a", int'(coef_a), ca);
      chk("coef_b", int'(coef_b), cb);
      chk("coef_c", int'(coef_c), cc);
      chk("coef_d", int'(coef_d), cd);
      chk("coef_e", int'(coef_e), ce);
      chk("coef_f", int'(coef_f), cf);
      chk("coef_g", int'(coef_g), cg);
    end
    nclr = never_m ? 1 : 7;
    chk("clr_pulses", clr_log.size(), nclr);
    for (int i = 0; i < nclr && i < clr_log.size(); i++)
      chk("probe_order", int'(clr_log[i]), (px[i] << 8) | (py[i] << 4) | pz[i]);
  endtask

  task automatic wait_clr(input int n);
    for (int i = 0; i < 2000 && clr_log.size() < n; i++) begin
      @(posedge clk); #1;
    end
    chk("wait_clr", clr_log.size() >= n ? 1 : 0, 1);
  endtask

  function automatic int rc();
    if ($urandom_range(0, 5) == 0) return int'($urandom_range(0, 39)) - 20;
    return int'($urandom_range(0, 31)) - 16;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1;
    rst = 1'b1;
    start = 1'b0;
    set_c(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_coef_valid", int'(coef_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_eval_clr", int'(eval_clr), 0);
    chk("rst_eval_en", int'(eval_en), 0);
    chk("rst_eval_in", int'({eval_in0, eval_in1, eval_in2}), 0);
    chk("rst_coef_a", int'(coef_a), 0);
    rst = 1'b0;

    set_c(5, 8, -4, 3, 6, -2, 13); lat = 10;
    run(t0, t1); check_result(t0, t1);
    chk("nominal_81", t1 - t0, 81);

    set_c(-16, 15, 15, -16, -1, 0, -16); lat = 1;
    run(t0, t1); check_result(t0, t1);
    hold_m = 1; lat = 4;
    run(t0, t1); check_result(t0, t1);
    hold_m = 0;

    bad_m = 1; set_c(5, 8, -4, 3, 6, -2, 13); lat = 3;
    run(t0, t1); check_result(t0, t1);
    bad_m = 0;

    never_m = 1;
    run(t0, t1); check_result(t0, t1);
    never_m = 0; lat = 2;
    run(t0, t1); check_result(t0, t1);

    set_c(20, 1, 2, 3, 4, 5, 6); lat = 2;
    run(t0, t1); check_result(t0, t1);

    // Start while busy is ignored; reset mid-run of point 3 clears everything.
    set_c(-7, 4, 9, -11, 2, 14, -3); lat = 6;
    clr_log.delete();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_clr(2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_clr(4);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_eval_en", int'(eval_en), 1);
    for (int i = 0; i < 4 && i < clr_log.size(); i++)
      chk("busy_start_ignored", int'(clr_log[i]), (px[i] << 8) | (py[i] << 4) | pz[i]);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_eval_en", int'(eval_en), 0);
    chk("mid_rst_eval_clr", int'(eval_clr), 0);
    chk("mid_rst_eval_in", int'({eval_in0, eval_in1, eval_in2}), 0);
    chk("mid_rst_coef_valid", int'(coef_valid), 0);
    chk("mid_rst_err", int'(err), 0);
    rst = 1'b0;
    run(t0, t1); check_result(t0, t1);

    for (int it = 0; it < 10; it++) begin
      set_c(rc(), rc(), rc(), rc(), rc(), rc(), rc());
      lat = int'($urandom_range(1, 12));
      hold_m = (lat >= 3) && ($urandom_range(0, 1) == 1);
      run(t0, t1); check_result(t0, t1);
    end
    hold_m = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
